// File: rtl/ysyx_24100006_mem_wb.sv
// ============================================================================
// Module  : ysyx_24100006_mem_wb
// Brief   : MEM->WB pipeline buffer, 2-entry skid FIFO between MEMU and WBU.
//           Optional EXU forwarding ports enabled by YSYX_24100006_MEMWB_FWD_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_24100006_mem_wb #(
    parameter int DATA_W = 32,
    parameter int GPR_AW = 4,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_irq,
    input  logic              in_is_break,
    input  logic              in_gpr_we,
    input  logic [GPR_AW-1:0] in_gpr_waddr,
    input  logic [DATA_W-1:0] in_gpr_wdata,
    input  logic              in_csr_we,
    input  logic [CSR_AW-1:0] in_csr_waddr,
    input  logic [DATA_W-1:0] in_csr_wdata,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_irq,
    output logic              out_is_break,
    output logic              out_gpr_we,
    output logic [GPR_AW-1:0] out_gpr_waddr,
    output logic [DATA_W-1:0] out_gpr_wdata,
    output logic              out_csr_we,
    output logic [CSR_AW-1:0] out_csr_waddr,
    output logic [DATA_W-1:0] out_csr_wdata
`ifdef YSYX_24100006_MEMWB_FWD_EN
    ,
    output logic              wb_fw_hit,
    output logic [GPR_AW-1:0] wb_fw_addr,
    output logic [DATA_W-1:0] wb_fw_data,
    output logic              wb_fw_tail_hit
`endif
);

    typedef struct packed {
        logic              irq;
        logic              is_break;
        logic              gpr_we;
        logic [GPR_AW-1:0] gpr_waddr;
        logic [DATA_W-1:0] gpr_wdata;
        logic              csr_we;
        logic [CSR_AW-1:0] csr_waddr;
        logic [DATA_W-1:0] csr_wdata;
    } entry_t;

    localparam logic [1:0] c_CNT_EMPTY = 2'd0;
    localparam logic [1:0] c_CNT_ONE   = 2'd1;
    localparam logic [1:0] c_CNT_FULL  = 2'd2;

    logic [1:0] count_q, count_d;
    entry_t     slot0_q, slot0_d;
    entry_t     slot1_q, slot1_d;
    entry_t     w_in_ent;
    logic       w_push;
    logic       w_pop;

    assign w_in_ent = '{
        irq:       in_irq,
        is_break:  in_is_break,
        gpr_we:    in_gpr_we,
        gpr_waddr: in_gpr_waddr,
        gpr_wdata: in_gpr_wdata,
        csr_we:    in_csr_we,
        csr_waddr: in_csr_waddr,
        csr_wdata: in_csr_wdata
    };

    // Handshake flags depend only on count_q, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != c_CNT_FULL);
    assign out_valid = (count_q != c_CNT_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (flush) begin
            count_d = c_CNT_EMPTY;
        end else begin
            case (count_q)
                c_CNT_EMPTY: begin
                    if (w_push) begin
                        slot0_d = w_in_ent;
                        count_d = c_CNT_ONE;
                    end
                end
                c_CNT_ONE: begin
                    if (w_push && w_pop) begin
                        slot0_d = w_in_ent;
                    end else if (w_push) begin
                        slot1_d = w_in_ent;
                        count_d = c_CNT_FULL;
                    end else if (w_pop) begin
                        count_d = c_CNT_EMPTY;
                    end
                end
                c_CNT_FULL: begin
                    if (w_pop) begin
                        slot0_d = slot1_q;
                        count_d = c_CNT_ONE;
                    end
                end
                default: begin
                    count_d = c_CNT_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= c_CNT_EMPTY;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    // Write enables are qualified so a stale head can never touch the register files.
    assign out_irq       = slot0_q.irq;
    assign out_is_break  = slot0_q.is_break;
    assign out_gpr_we    = slot0_q.gpr_we & out_valid;
    assign out_gpr_waddr = slot0_q.gpr_waddr;
    assign out_gpr_wdata = slot0_q.gpr_wdata;
    assign out_csr_we    = slot0_q.csr_we & out_valid;
    assign out_csr_waddr = slot0_q.csr_waddr;
    assign out_csr_wdata = slot0_q.csr_wdata;

`ifdef YSYX_24100006_MEMWB_FWD_EN
    assign wb_fw_hit      = out_valid & slot0_q.gpr_we & (slot0_q.gpr_waddr != '0);
    assign wb_fw_addr     = out_valid ? slot0_q.gpr_waddr : '0;
    assign wb_fw_data     = out_valid ? slot0_q.gpr_wdata : '0;
    assign wb_fw_tail_hit = (count_q == c_CNT_FULL) & slot1_q.gpr_we & (slot1_q.gpr_waddr != '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100006_mem_wb.sv
// ============================================================================
// Module  : tb_ysyx_24100006_mem_wb
// Brief   : Scoreboard bench for the MEM->WB skid buffer, directed plus random.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ysyx_24100006_mem_wb;

    typedef struct packed {
        logic        irq;
        logic        brk;
        logic        gwe;
        logic [3:0]  gad;
        logic [31:0] gwd;
        logic        cwe;
        logic [11:0] cad;
        logic [31:0] cwd;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    ent_t        in_e;
    wire         in_ready;
    wire         out_valid;
    wire         out_irq, out_is_break, out_gpr_we, out_csr_we;
    wire [3:0]   out_gpr_waddr;
    wire [31:0]  out_gpr_wdata, out_csr_wdata;
    wire [11:0]  out_csr_waddr;
`ifdef YSYX_24100006_MEMWB_FWD_EN
    wire         wb_fw_hit, wb_fw_tail_hit;
    wire [3:0]   wb_fw_addr;
    wire [31:0]  wb_fw_data;
`endif

    ysyx_24100006_mem_wb #(.DATA_W(32), .GPR_AW(4), .CSR_AW(12)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_irq        (in_e.irq),
        .in_is_break   (in_e.brk),
        .in_gpr_we     (in_e.gwe),
        .in_gpr_waddr  (in_e.gad),
        .in_gpr_wdata  (in_e.gwd),
        .in_csr_we     (in_e.cwe),
        .in_csr_waddr  (in_e.cad),
        .in_csr_wdata  (in_e.cwd),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_irq       (out_irq),
        .out_is_break  (out_is_break),
        .out_gpr_we    (out_gpr_we),
        .out_gpr_waddr (out_gpr_waddr),
        .out_gpr_wdata (out_gpr_wdata),
        .out_csr_we    (out_csr_we),
        .out_csr_waddr (out_csr_waddr),
        .out_csr_wdata (out_csr_wdata)
`ifdef YSYX_24100006_MEMWB_FWD_EN
        ,
        .wb_fw_hit     (wb_fw_hit),
        .wb_fw_addr    (wb_fw_addr),
        .wb_fw_data    (wb_fw_data),
        .wb_fw_tail_hit(wb_fw_tail_hit)
`endif
    );

    int   n_vec = 0;
    int   n_err = 0;
    ent_t sb[$];       // expected buffer contents, oldest first
    int   m_cnt = 0;   // model occupancy seen by the WBU side this cycle

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.irq = 1'($urandom);
        e.brk = 1'($urandom);
        e.gwe = 1'($urandom);
        e.gad = 4'($urandom);
        e.gwd = $urandom;
        e.cwe = 1'($urandom);
        e.cad = 12'($urandom);
        e.cwd = $urandom;
        return e;
    endfunction

    function automatic ent_t mk(input logic [3:0] gad, input logic [31:0] gwd);
        ent_t e;
        e     = rnd_ent();
        e.gwe = 1'b1;
        e.gad = gad;
        e.gwd = gwd;
        return e;
    endfunction

    // Called at posedge+1: inputs apply for the coming edge; accepted pushes enter the scoreboard.
    task automatic drive(input bit iv, input bit ordy, input bit fl, input ent_t e);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_e      = e;
        if (iv && m_cnt != 2 && !fl) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares registered outputs mid-cycle and retires the head on a handshake.
    always @(negedge clk) begin
        ent_t act;
        if (!reset) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            act = {out_irq, out_is_break, out_gpr_we, out_gpr_waddr, out_gpr_wdata,
                   out_csr_we, out_csr_waddr, out_csr_wdata};
            chk("in_ready", 128'(in_ready), 128'(m_cnt != 2));
            chk("out_valid", 128'(out_valid), 128'(m_cnt != 0));
            if (m_cnt != 0 && sb.size() > 0)
                chk("head", 128'(act), 128'(sb[0]));
            else
                chk("we_gate", 128'({out_gpr_we, out_csr_we}), 128'(0));
`ifdef YSYX_24100006_MEMWB_FWD_EN
            begin
                logic        e_hit, e_thit;
                logic [3:0]  e_addr;
                logic [31:0] e_data;
                e_hit  = 1'b0; e_thit = 1'b0; e_addr = '0; e_data = '0;
                if (m_cnt != 0 && sb.size() > 0) begin
                    e_hit  = sb[0].gwe && (sb[0].gad != 4'd0);
                    e_addr = sb[0].gad;
                    e_data = sb[0].gwd;
                end
                if (m_cnt == 2 && sb.size() > 1)
                    e_thit = sb[1].gwe && (sb[1].gad != 4'd0);
                chk("fw_hit", 128'(wb_fw_hit), 128'(e_hit));
                chk("fw_addr", 128'(wb_fw_addr), 128'(e_addr));
                chk("fw_data", 128'(wb_fw_data), 128'(e_data));
                chk("fw_tail_hit", 128'(wb_fw_tail_hit), 128'(e_thit));
            end
`endif
            if (flush) begin
                sb.delete();
                m_cnt = 0;
            end else begin
                if (m_cnt != 0 && out_ready && sb.size() > 0) void'(sb.pop_front());
                m_cnt = sb.size();
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_e      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_fields", 128'({out_irq, out_is_break, out_gpr_we, out_gpr_waddr, out_gpr_wdata,
                                out_csr_we, out_csr_waddr, out_csr_wdata}), 128'(0));
        reset = 1'b1;

        // single pass
        drive(1, 1, 0, mk(4'd5, 32'hDEADBEEF));
        drive(0, 1, 0, rnd_ent());
        chk("single_drained", 128'(out_valid), 128'(0));

        // stall fill, then release
        drive(1, 0, 0, mk(4'd1, 32'h11));
        drive(1, 0, 0, mk(4'd2, 32'h22));
        chk("fill_in_ready", 128'(in_ready), 128'(0));
        drive(0, 1, 0, rnd_ent());
        chk("pop1_in_ready", 128'(in_ready), 128'(1));
        drive(0, 1, 0, rnd_ent());
        drive(0, 1, 0, rnd_ent());

        // streaming
        for (int i = 0; i < 16; i++) drive(1, 1, 0, rnd_ent());
        drive(0, 1, 0, rnd_ent());

        // flush at count 2 with a push of C and out_ready high
        drive(1, 0, 0, mk(4'd6, 32'hA));
        drive(1, 0, 0, mk(4'd7, 32'hB));
        drive(1, 1, 1, mk(4'd8, 32'hC));
        chk("flush_valid", 128'(out_valid), 128'(0));
        // flush at count 1 drops the accepted push
        drive(1, 0, 0, mk(4'd9, 32'hD));
        drive(1, 1, 1, mk(4'd10, 32'hC));
        drive(0, 1, 0, rnd_ent());

        // forwarding heads: x0 then x3
        drive(1, 0, 0, mk(4'd0, 32'h55));
        drive(1, 0, 0, mk(4'd3, 32'h7));
        drive(0, 1, 0, rnd_ent());
        drive(0, 0, 0, rnd_ent());
        drive(0, 1, 0, rnd_ent());

        // reset mid-stall at count 2
        drive(1, 0, 0, mk(4'd4, 32'h44));
        drive(1, 0, 0, mk(4'd5, 32'h55));
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_gpr_we", 128'(out_gpr_we), 128'(0));
        sb.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // randomized traffic
        for (int i = 0; i < 1500; i++)
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0, rnd_ent());
        for (int i = 0; i < 3; i++) drive(0, 1, 0, rnd_ent());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
